// File: rtl/mc14500b_prog_loader.sv
// Serial program loader for an MC14500B system: parses HEADER/A/L/payload/C
// frames, writes the payload into program RAM and releases the CPU on a good checksum.
module mc14500b_prog_loader #(
  parameter logic [7:0] START_DEFAULT = 8'h00,
  parameter logic [7:0] HEADER        = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic       MEM_WE,
  output logic [7:0] MEM_ADDR,
  output logic [7:0] MEM_WDATA,
  output logic       CPU_RST,
  output logic [7:0] START_ADDR,
  output logic       LOADED,
  output logic       ERROR
);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, RUN, ERR} state_t;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] start_q, start_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_we_q, mem_we_d;
  logic       cpu_rst_q, cpu_rst_d;
  logic       loaded_q, loaded_d;
  logic       error_q, error_d;
  logic [7:0] sum_next;

  assign sum_next = sum_q + RX_DATA;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    start_d     = start_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_rst_d   = cpu_rst_q;
    loaded_d    = loaded_q;
    error_d     = error_q;

    if (RX_VALID) begin
      unique case (state_q)
        IDLE, RUN, ERR: begin
          if (RX_DATA == HEADER) begin
            state_d   = ADDR;
            cpu_rst_d = 1'b1;
            loaded_d  = 1'b0;
            error_d   = 1'b0;
            sum_d     = 8'h00;
          end
        end
        ADDR: begin
          ptr_d   = RX_DATA;
          cand_d  = RX_DATA;
          sum_d   = sum_next;
          state_d = LEN;
        end
        LEN: begin
          // A length byte of zero counts down through 0xFF, giving 256 payload bytes.
          cnt_d   = RX_DATA;
          sum_d   = sum_next;
          state_d = DATA;
        end
        DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = RX_DATA;
          ptr_d       = ptr_q + 8'd1;
          cnt_d       = cnt_q - 8'd1;
          sum_d       = sum_next;
          if (cnt_q == 8'd1) state_d = CSUM;
        end
        CSUM: begin
          sum_d = sum_next;
          if (sum_next == 8'h00) begin
            start_d   = cand_q;
            cpu_rst_d = 1'b0;
            loaded_d  = 1'b1;
            state_d   = RUN;
          end else begin
            error_d = 1'b1;
            state_d = ERR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= 8'h00;
      cand_q      <= 8'h00;
      cnt_q       <= 8'h00;
      sum_q       <= 8'h00;
      start_q     <= START_DEFAULT;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      start_q     <= start_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_rst_q   <= cpu_rst_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
    end
  end

  assign RX_READY   = 1'b1;
  assign MEM_WE     = mem_we_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign CPU_RST    = cpu_rst_q;
  assign START_ADDR = start_q;
  assign LOADED     = loaded_q;
  assign ERROR      = error_q;

endmodule

// File: tb/tb_mc14500b_prog_loader.sv
// Scoreboard bench for mc14500b_prog_loader: frames are built at byte level, expected
// RAM writes are queued per frame and popped by a monitor on every write strobe.
module tb_mc14500b_prog_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       RX_READY, MEM_WE, CPU_RST, LOADED, ERROR;
  logic [7:0] MEM_ADDR, MEM_WDATA, START_ADDR;

  mc14500b_prog_loader dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .CPU_RST(CPU_RST),
    .START_ADDR(START_ADDR), .LOADED(LOADED), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [15:0] wq[$];
  logic [15:0] exp_w;
  logic [7:0]  pay[256];
  logic [7:0]  exp_start = 8'h00;
  logic        exp_loaded = 1'b0, exp_error = 1'b0, exp_cpu_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=no_write", MEM_ADDR, MEM_WDATA);
      end else begin
        exp_w = wq.pop_front();
        check("mem_write", 32'({MEM_ADDR, MEM_WDATA}), 32'(exp_w));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // One accepted byte, then gap cycles with RX_VALID low and junk on RX_DATA.
  task automatic send_byte(input logic [7:0] b, input int gap);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  function automatic logic [7:0] good_csum(input logic [7:0] a, input int n);
    int s;
    s = a + (n % 256);
    for (int i = 0; i < n; i++) s += pay[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Everything after the header byte; the model updates from the checksum rule.
  task automatic send_body(input logic [7:0] a, input int n, input logic [7:0] c,
                           input int gmin, input int gmax);
    int s;
    s = a + (n % 256) + c;
    for (int i = 0; i < n; i++) begin
      s += pay[i];
      wq.push_back({8'((a + i) % 256), pay[i]});
    end
    send_byte(a, $urandom_range(gmax, gmin));
    send_byte(8'(n % 256), $urandom_range(gmax, gmin));
    for (int i = 0; i < n; i++) send_byte(pay[i], $urandom_range(gmax, gmin));
    send_byte(c, 0);
    if (s % 256 == 0) begin
      exp_start = a; exp_loaded = 1'b1; exp_error = 1'b0; exp_cpu_rst = 1'b0;
    end else begin
      exp_loaded = 1'b0; exp_error = 1'b1; exp_cpu_rst = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] c,
                            input int gmin, input int gmax);
    send_byte(HDR, $urandom_range(gmax, gmin));
    exp_loaded = 1'b0; exp_error = 1'b0; exp_cpu_rst = 1'b1;
    send_body(a, n, c, gmin, gmax);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cpu_rst"}, 32'(CPU_RST), 32'(exp_cpu_rst));
    check({tag, "_loaded"}, 32'(LOADED), 32'(exp_loaded));
    check({tag, "_error"}, 32'(ERROR), 32'(exp_error));
    check({tag, "_start_addr"}, 32'(START_ADDR), 32'(exp_start));
    check({tag, "_rx_ready"}, 32'(RX_READY), 32'd1);
    check({tag, "_writes_drained"}, 32'(wq.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] a, c, nb;
    int n;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_mem_we", 32'(MEM_WE), 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
    check_status("rst");
    RST = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end

    // Bad checksum: writes land, start address stays at its default.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(8'h10, 3, 8'h70, 0, 1);
    check_status("bad_frame");
    check("bad_frame_error_hi", 32'(ERROR), 32'd1);

    // Same frame with the checksum that makes the frame sum to zero.
    send_frame(8'h10, 3, good_csum(8'h10, 3), 0, 1);
    check_status("good_frame");
    check("good_frame_start", 32'(START_ADDR), 32'h10);

    // Pointer wrap across 0xFF.
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_frame(8'hFE, 3, good_csum(8'hFE, 3), 0, 2);
    check_status("wrap");
    check("wrap_start", 32'(START_ADDR), 32'hFE);

    // Noise ignored; header value inside payload is data.
    send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'h5A, 2);
    check_status("noise");
    pay[0] = 8'h77; pay[1] = HDR; pay[2] = 8'h01; pay[3] = HDR;
    send_frame(8'h40, 4, good_csum(8'h40, 4), 0, 1);
    check_status("hdr_in_payload");

    // Reset arrives together with the third payload byte.
    pay[0] = 8'hC1; pay[1] = 8'hC2;
    wq.push_back({8'h80, 8'hC1});
    wq.push_back({8'h81, 8'hC2});
    send_byte(HDR, 0); send_byte(8'h80, 0); send_byte(8'h03, 0);
    send_byte(8'hC1, 0); send_byte(8'hC2, 0);
    RX_DATA = 8'hC3; RX_VALID = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; RX_VALID = 1'b0;
    exp_start = 8'h00; exp_loaded = 1'b0; exp_error = 1'b0; exp_cpu_rst = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    check("midrst_mem_we", 32'(MEM_WE), 32'd0);
    check_status("midrst");
    send_byte(8'h33, 1);
    check_status("midrst_idle");
    pay[0] = 8'h5C; pay[1] = 8'h6D;
    send_frame(8'h20, 2, good_csum(8'h20, 2), 0, 1);
    check_status("after_rst");

    // Header in RUN re-arms CPU reset on the next cycle; fixed 5-cycle gaps throughout.
    send_byte(HDR, 0);
    check("rerun_cpu_rst", 32'(CPU_RST), 32'd1);
    check("rerun_loaded", 32'(LOADED), 32'd0);
    repeat (5) begin @(posedge CLK); #1; end
    exp_loaded = 1'b0; exp_error = 1'b0; exp_cpu_rst = 1'b1;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_body(8'h10, 3, good_csum(8'h10, 3), 5, 5);
    check_status("gap5");

    // Randomised frames with noise, occasional bad checksums and one 256-byte load.
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        nb = 8'($urandom);
        if (nb == HDR) nb = 8'h00;
        send_byte(nb, $urandom_range(1, 0));
      end
      a = 8'($urandom);
      n = (f == 10) ? 256 : int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) pay[i] = ($urandom_range(7, 0) == 0) ? HDR : 8'($urandom);
      c = good_csum(a, n);
      if ($urandom_range(3, 0) == 0) c = c + 8'($urandom_range(255, 1));
      send_frame(a, n, c, 0, 2);
      check_status("rand");
    end

    check("final_queue_empty", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
